// File: rtl/pdm_pkg.sv
// Constants and state type shared by the PDM serializer and deserializer.
package pdm_pkg;
  localparam int PDM_WORD_W          = 16;
  localparam int PDM_CLK_DIV_DEFAULT = 50;

  typedef enum logic {IDLE, SHIFT} pdm_tx_state_t;
endpackage

// File: rtl/pdm_clk_gen.sv
// Divided PDM bit clock with single-cycle rise/fall tick strobes; parks low when idle.
module pdm_clk_gen
  import pdm_pkg::*;
#(
  parameter int CLK_DIV = PDM_CLK_DIV_DEFAULT
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic run_i,
  output logic pdm_clk_o,
  output logic rise_tick_o,
  output logic fall_tick_o
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_q;
  logic          clk_q;
  logic          wrap;

  assign wrap        = run_i && (div_q == DW'(CLK_DIV - 1));
  assign rise_tick_o = wrap && !clk_q;
  assign fall_tick_o = wrap &&  clk_q;
  assign pdm_clk_o   = clk_q;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      div_q <= '0;
      clk_q <= 1'b0;
    end else if (!run_i) begin
      div_q <= '0;
      clk_q <= 1'b0;
    end else if (wrap) begin
      div_q <= '0;
      clk_q <= ~clk_q;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end
endmodule

// File: rtl/pdm_serializer.sv
// PDM transmit path: 1-deep holding register feeding an MSB-first shifter
// that updates the serial line on falling ticks of the locally divided bit clock.
module pdm_serializer
  import pdm_pkg::*;
#(
  parameter int CLK_DIV = PDM_CLK_DIV_DEFAULT,
  parameter int WORD_W  = PDM_WORD_W
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic [WORD_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              pdm_clk_o,
  output logic              pdm_data_o,
  output logic              done_o,
  output logic              underrun_o
);
  localparam int BW = $clog2(WORD_W);

  pdm_tx_state_t     state_q;
  logic [WORD_W-1:0] hold_q, shift_q;
  logic [BW-1:0]     bit_cnt_q;
  logic              hold_full_q, data_q, done_q, underrun_q;
  logic              clk_run, fall_tick, accept;

  // Keep the clock alive until the word in flight finishes and the line is back low.
  assign clk_run    = enable_i || (state_q == SHIFT) || pdm_clk_o;
  assign accept     = valid_i && !hold_full_q;
  assign ready_o    = !hold_full_q;
  assign pdm_data_o = data_q;
  assign done_o     = done_q;
  assign underrun_o = underrun_q;

  pdm_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .run_i       (clk_run),
    .pdm_clk_o   (pdm_clk_o),
    .rise_tick_o (),
    .fall_tick_o (fall_tick)
  );

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      hold_full_q <= 1'b0;
      data_q      <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      if (accept) begin
        hold_q      <= data_i;
        hold_full_q <= 1'b1;
      end
      if (fall_tick) begin
        unique case (state_q)
          IDLE: begin
            data_q <= 1'b0;
            if (hold_full_q && enable_i) begin
              shift_q     <= hold_q;
              bit_cnt_q   <= '0;
              data_q      <= hold_q[WORD_W-1];
              hold_full_q <= 1'b0;
              state_q     <= SHIFT;
            end
          end
          SHIFT: begin
            if (bit_cnt_q != BW'(WORD_W - 1)) begin
              shift_q   <= shift_q << 1;
              data_q    <= shift_q[WORD_W-2];
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end else begin
              done_q <= 1'b1;
              // Reload on the same tick so consecutive words have no gap bit.
              if (hold_full_q && enable_i) begin
                shift_q     <= hold_q;
                bit_cnt_q   <= '0;
                data_q      <= hold_q[WORD_W-1];
                hold_full_q <= 1'b0;
              end else begin
                underrun_q <= enable_i;
                data_q     <= 1'b0;
                state_q    <= IDLE;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/pdm_serializer.md
Name: pdm_serializer

Overview:
- Transmit-side counterpart of the PDM Deserializer.
- Accepts 16-bit words over a valid/ready handshake and buffers one word.
- Shifts each word out MSB-first on a 1-bit serial line, with a divided bit clock generated locally.
- Feeds the audio-out path and loops back to the Deserializer for board-level test.

Parameters:
- CLK_DIV, 50: system clocks per pdm_clk_o half-period (100 MHz / (2*50) = 1 MHz bit clock); legal range 2..255.
- WORD_W, 16: bits per word; the shift counter is $clog2(WORD_W) wide.

Ports:
- clock_i  input  1  system clock; all logic on the rising edge.
- reset_i  input  1  asynchronous, active-low reset.
- enable_i  input  1  run request; low stops transmission at the next word boundary.
- data_i  input  WORD_W  word to transmit.
- valid_i  input  1  data_i is valid.
- ready_o  output  1  holding register empty; a word is accepted when valid_i && ready_o.
- pdm_clk_o  output  1  serial bit clock; the receiver samples on its rising edge.
- pdm_data_o  output  1  serial data; changes only on a falling tick of pdm_clk_o.
- done_o  output  1  one-cycle pulse when the last bit of a word completes.
- underrun_o  output  1  one-cycle pulse when a word ends with enable_i=1 and no word is buffered.

Behaviour:
- Reset (reset_i=0, async):
  - State IDLE, div_cnt=0, bit_cnt=0, hold_full=0.
  - pdm_clk_o=0, pdm_data_o=0, done_o=0, underrun_o=0, ready_o=1.
- Clock generator:
  - clk_run = enable_i || state==SHIFT || pdm_clk_o==1.
  - While clk_run: div_cnt counts 0..CLK_DIV-1 and wraps.
  - On wrap, pdm_clk_o toggles. A 0->1 toggle is a rise tick; a 1->0 toggle is a fall tick.
  - While !clk_run: div_cnt holds 0 and pdm_clk_o parks low.
- Holding register (1 deep):
  - ready_o = !hold_full (registered state, combinational output).
  - Accept writes data_i into hold and sets hold_full.
  - A load from hold into the shift register clears hold_full on the same edge. A new accept is possible the following cycle.
  - Accept and load can never coincide, because load requires hold_full=1.
- State machine IDLE/SHIFT:
  - IDLE: pdm_data_o=0. On a fall tick with hold_full && enable_i: load shift_reg, bit_cnt=0, pdm_data_o=hold[WORD_W-1], go to SHIFT.
  - SHIFT, fall tick with bit_cnt<WORD_W-1: shift left, pdm_data_o=next bit, bit_cnt++.
  - SHIFT, fall tick with bit_cnt==WORD_W-1: done_o=1 for one cycle, then:
    - if hold_full && enable_i: reload immediately (no gap bit), stay in SHIFT.
    - else if enable_i: underrun_o=1 for one cycle, go to IDLE, pdm_data_o=0.
    - else: go to IDLE, pdm_data_o=0, no underrun.
- enable_i low mid-word: the current word completes in full; no new load occurs; the clock parks low after its next fall tick.
- Latency: from a word accepted in IDLE with the clock running, the MSB appears at the next fall tick. Each bit lasts 2*CLK_DIV system cycles.
- Reset mid-word: the word is abandoned and outputs return to reset values asynchronously. No done_o is issued for that word.

Decomposition:
- pdm_pkg holds:
  - PDM_WORD_W=16 and PDM_CLK_DIV_DEFAULT=50, shared with the Deserializer.
  - typedef enum logic {IDLE, SHIFT} pdm_tx_state_t.
- Sub-module pdm_clk_gen:
  - Contains the divider and pdm_clk_o register.
  - Inputs: run. Outputs: pdm_clk_o, rise_tick, fall_tick.
  - Reusable by the Deserializer.

Test Plan (CLK_DIV=2, so one bit = 4 cycles):
- Single word: reset 100 ns, enable_i=1, send 0xA5C3 -> bits 1010_0101_1100_0011 sampled on 16 consecutive rising edges; one done_o pulse 64 cycles after MSB; one underrun_o pulse; then IDLE with pdm_data_o=0.
- Back-to-back: send 0x8001, then 0x7FFE as soon as ready_o=1 -> 32 contiguous bits with no gap; two done_o pulses 64 cycles apart; no underrun_o until after the second word.
- Backpressure: while shifting with hold full, hold valid_i=1 with 0x1234 -> ready_o=0 and the word is not lost; it is accepted on the cycle after the reload; the transmitted word equals 0x1234.
- Enable drop: drop enable_i after bit 5 of 0xFFFF -> all 16 ones are sent; done_o=1, underrun_o=0; pdm_clk_o parks low and stays low.
- Reset mid-word: assert reset_i=0 at bit 8 -> pdm_clk_o, pdm_data_o, done_o=0 and ready_o=1 immediately; the next word 0x00FF transmits correctly after release.
- Loopback: connect pdm_data_o to the Deserializer's pdm_data_i, send 0x5A5A -> Deserializer data_o=0x5A5A with done_o.
